debug_rx_controller: RTL and testbench

DEBUG_RX_CONTROLLER -- requirements
Module: debug_rx_controller

---
 rtl/debug_pkg.sv | 20 ++
 rtl/rx_timeout_timer.sv | 30 +++
 rtl/debug_rx_controller.sv | 154 +++++++++++++++
 tb/tb_debug_rx_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug receive controller.
// Opcodes, state encoding and instruction word width.
package debug_pkg;

  localparam int WORD_W = 32;

  localparam logic [7:0] OP_LOAD = 8'h01;
  localparam logic [7:0] OP_STEP = 8'h02;
  localparam logic [7:0] OP_RUN  = 8'h03;
  localparam logic [7:0] OP_RST  = 8'h04;
  localparam logic [7:0] OP_STOP = 8'h05;

  typedef enum logic [1:0] {
    IDLE,
    GET_COUNT,
    GET_WORD,
    RUNNING
  } state_t;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte inactivity timer for multi-byte commands.
// Flags expiry once TIMEOUT cycles pass without a reload.
module rx_timeout_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  assign expired = enable && !reload
                && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || reload) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/debug_rx_controller.sv
// Byte-command controller: loads instruction memory and
// drives CPU run / step / reset from a UART byte stream.
module debug_rx_controller
  import debug_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done_tick,
  input  logic [7:0]        i_rx_data,
  input  logic              i_cpu_halted,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_wr_data,
  output logic              o_cpu_run,
  output logic              o_cpu_step,
  output logic              o_cpu_rst,
  output logic              o_load_done,
  output logic              o_error,
  output logic              o_busy
);

  state_t              state, state_n;
  logic [7:0]          remain, remain_n;
  logic [1:0]          byte_cnt, byte_cnt_n;
  logic [23:0]         buf_q, buf_n;
  logic [ADDR_W-1:0]   addr, addr_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [WORD_W-1:0]   wr_data_n;
  logic                wr_en_n, step_n, cpu_rst_n;
  logic                done_n, error_n;
  logic                expired;

  rx_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .enable  ((state == GET_COUNT) || (state == GET_WORD)),
    .reload  (i_rx_done_tick),
    .expired (expired)
  );

  always_comb begin
    state_n    = state;
    remain_n   = remain;
    byte_cnt_n = byte_cnt;
    buf_n      = buf_q;
    addr_n     = addr;
    mem_addr_n = o_mem_addr;
    wr_data_n  = o_mem_wr_data;
    wr_en_n    = 1'b0;
    step_n     = 1'b0;
    cpu_rst_n  = 1'b0;
    done_n     = 1'b0;
    error_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_rx_done_tick) begin
          unique case (1'b1)
            i_rx_data == OP_LOAD: state_n   = GET_COUNT;
            i_rx_data == OP_STEP: step_n    = 1'b1;
            i_rx_data == OP_RUN:  state_n   = RUNNING;
            i_rx_data == OP_RST:  cpu_rst_n = 1'b1;
            default:              error_n   = 1'b1;
          endcase
        end
      end
      GET_COUNT: begin
        if (i_rx_done_tick) begin
          remain_n   = i_rx_data;
          addr_n     = '0;
          byte_cnt_n = '0;
          if (i_rx_data == 8'd0) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = GET_WORD;
          end
        end else if (expired) begin
          error_n = 1'b1;
          state_n = IDLE;
        end
      end
      GET_WORD: begin
        if (i_rx_done_tick) begin
          byte_cnt_n = byte_cnt + 2'd1;
          // little-endian: earlier bytes shift toward bit 0
          buf_n = {i_rx_data, buf_q[23:8]};
          if (byte_cnt == 2'd3) begin
            wr_en_n    = 1'b1;
            mem_addr_n = addr;
            wr_data_n  = {i_rx_data, buf_q};
            addr_n     = addr + ADDR_W'(1);
            remain_n   = remain - 8'd1;
            if (remain == 8'd1) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end
          end
        end else if (expired) begin
          error_n    = 1'b1;
          byte_cnt_n = '0;
          state_n    = IDLE;
        end
      end
      RUNNING: begin
        if (i_cpu_halted ||
            (i_rx_done_tick && i_rx_data == OP_STOP)) begin
          state_n = IDLE;
        end else if (i_rx_done_tick) begin
          error_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      remain        <= '0;
      byte_cnt      <= '0;
      buf_q         <= '0;
      addr          <= '0;
      o_mem_wr_en   <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wr_data <= '0;
      o_cpu_run     <= 1'b0;
      o_cpu_step    <= 1'b0;
      o_cpu_rst     <= 1'b0;
      o_load_done   <= 1'b0;
      o_error       <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_n;
      remain        <= remain_n;
      byte_cnt      <= byte_cnt_n;
      buf_q         <= buf_n;
      addr          <= addr_n;
      o_mem_wr_en   <= wr_en_n;
      o_mem_addr    <= mem_addr_n;
      o_mem_wr_data <= wr_data_n;
      o_cpu_run     <= (state_n == RUNNING);
      o_cpu_step    <= step_n;
      o_cpu_rst     <= cpu_rst_n;
      o_load_done   <= done_n;
      o_error       <= error_n;
      o_busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_debug_rx_controller.sv
// Scoreboard bench for debug_rx_controller.
// Expected pulses are queued at drive time, popped on output.
module tb_debug_rx_controller;

  localparam int AW = 2;
  localparam int TO = 20;

  localparam int M_WR   = 1;
  localparam int M_DONE = 2;
  localparam int M_STEP = 4;
  localparam int M_RST  = 8;
  localparam int M_ERR  = 16;

  typedef struct {
    int          kind;
    int          cyc;
    logic [1:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [7:0]  data;
  logic        halted;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic        run, step, cpu_rst, done, err, busy;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  q[$];
  logic [31:0] w;
  int   base;

  debug_rx_controller #(
    .ADDR_W  (AW),
    .TIMEOUT (TO)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_done_tick (tick),
    .i_rx_data      (data),
    .i_cpu_halted   (halted),
    .o_mem_wr_en    (wr_en),
    .o_mem_addr     (addr),
    .o_mem_wr_data  (wdata),
    .o_cpu_run      (run),
    .o_cpu_step     (step),
    .o_cpu_rst      (cpu_rst),
    .o_load_done    (done),
    .o_error        (err),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input int c,
                      input logic [1:0] a,
                      input logic [31:0] d);
    ev_t e;
    for (int b = 0; b < 5; b++) begin
      if (m[b]) begin
        e.kind = 1 << b;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic take(input int kind,
                      input logic [1:0] a,
                      input logic [31:0] d);
    ev_t e;
    if (q.size() == 0) begin
      chk("spurious", kind, 0);
    end else begin
      e = q.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cyc", cyc, e.cyc);
      if (kind == M_WR) begin
        chk("wr_addr", a, e.addr);
        chk("wr_data", d, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en)   take(M_WR, addr, wdata);
      if (done)    take(M_DONE, 0, 0);
      if (step)    take(M_STEP, 0, 0);
      if (cpu_rst) take(M_RST, 0, 0);
      if (err)     take(M_ERR, 0, 0);
    end
  end

  task automatic send(input logic [7:0] b,
                      input int m = 0,
                      input logic [1:0] a = 0,
                      input logic [31:0] d = 0);
    @(negedge clk);
    tick = 1'b1;
    data = b;
    push(m, cyc + 1, a, d);
    @(negedge clk);
    tick = 1'b0;
  endtask

  function automatic logic [40:0] all_outs();
    return {wr_en, addr, wdata, run, step,
            cpu_rst, done, err, busy};
  endfunction

  initial begin
    rst_n  = 1'b0;
    tick   = 1'b0;
    data   = 8'h00;
    halted = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", all_outs(), 0);

    send(8'h01);
    chk("load_busy", busy, 1);
    send(8'h02);
    send(8'h78); send(8'h56); send(8'h34);
    send(8'h12, M_WR, 2'd0, 32'h12345678);
    send(8'hEF); send(8'hBE); send(8'hAD);
    send(8'hDE, M_WR | M_DONE, 2'd1, 32'hDEADBEEF);
    chk("load_end_busy", busy, 0);

    send(8'h01);
    send(8'h00, M_DONE);
    chk("n0_busy", busy, 0);

    send(8'h02, M_STEP);
    send(8'h04, M_RST);
    send(8'h7F, M_ERR);
    chk("err_busy", busy, 0);

    send(8'h03);
    chk("run_on", run, 1);
    chk("run_busy", busy, 1);
    send(8'h33, M_ERR);
    chk("run_keep", run, 1);
    @(negedge clk);
    halted = 1'b1;
    @(negedge clk);
    halted = 1'b0;
    chk("halt_run", run, 0);
    chk("halt_busy", busy, 0);

    send(8'h03);
    chk("run2_on", run, 1);
    send(8'h05);
    chk("stop_run", run, 0);
    chk("stop_busy", busy, 0);

    send(8'h03);
    @(negedge clk);
    tick   = 1'b1;
    data   = 8'h05;
    halted = 1'b1;
    @(negedge clk);
    tick   = 1'b0;
    halted = 1'b0;
    chk("both_run", run, 0);
    chk("both_busy", busy, 0);

    send(8'h01);
    send(8'h01);
    send(8'hAA);
    base = cyc;
    push(M_ERR, base + TO, 0, 0);
    repeat (TO + 5) @(negedge clk);
    chk("to_busy", busy, 0);

    send(8'h01);
    send(8'h05);
    for (int i = 0; i < 5; i++) begin
      w = 32'hC0DE0000 | i;
      send(w[7:0]);
      send(w[15:8]);
      send(w[23:16]);
      send(w[31:24], (i == 4) ? (M_WR | M_DONE) : M_WR,
           i[1:0], w);
    end
    chk("wrap_busy", busy, 0);

    send(8'h01);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h02, M_STEP);
    repeat (TO + 5) @(negedge clk);
    chk("after_rst_busy", busy, 0);

    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
